// File: rtl/imm_pkg.sv
// Shared opcode constants and encoder state type for the immediate encoder and
// the decode-stage extender.
package imm_pkg;

  localparam logic [5:0]  OP_ADDI   = 6'b001000;
  localparam logic [5:0]  OP_ORI    = 6'b001101;
  localparam logic [5:0]  OP_LUI    = 6'b001111;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EMIT_ONE = 2'd1,
    EMIT_HI  = 2'd2,
    EMIT_LO  = 2'd3
  } enc_state_t;

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request / instruction-word bus of the immediate encoder.
// Valid/ready: a beat moves on a rising edge where valid && ready; the sender
// holds its payload stable while valid=1 and ready=0.
interface imm_encoder_if #(parameter int CNT_W = 16);
  logic             i_valid;
  logic             o_ready;
  logic [31:0]      i_data_value;
  logic [4:0]       i_data_rt;
  logic             o_valid;
  logic             i_ready;
  logic [31:0]      o_data_instr;
  logic             o_data_last;
  logic [CNT_W-1:0] o_data_count;

  modport master (
    output i_valid, i_data_value, i_data_rt, i_ready,
    input  o_ready, o_valid, o_data_instr, o_data_last, o_data_count
  );

  modport slave (
    input  i_valid, i_data_value, i_data_rt, i_ready,
    output o_ready, o_valid, o_data_instr, o_data_last, o_data_count
  );
endinterface

// File: rtl/imm_classify.sv
// Picks the shortest load sequence for a constant: one word (NOP/ADDI/ORI/LUI)
// or the LUI+ORI pair.
module imm_classify
  import imm_pkg::*;
(
  input  logic [31:0] value,
  input  logic [4:0]  rt,
  output logic        two_word,
  output logic [31:0] word0,
  output logic [31:0] word1
);
  logic [15:0] lo;
  logic [15:0] hi;

  assign lo = value[15:0];
  assign hi = value[31:16];

  always_comb begin
    two_word = 1'b0;
    word0    = INSTR_NOP;
    word1    = i_type(OP_ORI, rt, rt, lo);
    // Ordered so each test only fires when the cheaper encodings failed.
    if (rt == 5'd0) begin
      word0 = INSTR_NOP;
    end else if ((&value[31:15]) || (~|value[31:15])) begin
      word0 = i_type(OP_ADDI, 5'd0, rt, lo);
    end else if (hi == 16'd0) begin
      word0 = i_type(OP_ORI, 5'd0, rt, lo);
    end else if (lo == 16'd0) begin
      word0 = i_type(OP_LUI, 5'd0, rt, hi);
    end else begin
      two_word = 1'b1;
      word0    = i_type(OP_LUI, 5'd0, rt, hi);
    end
  end
endmodule

// File: rtl/imm_encoder.sv
// Turns a 32-bit constant and destination register into the shortest MIPS
// load sequence, one registered word at a time.
module imm_encoder
  import imm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  imm_encoder_if.slave bus,
  output enc_state_t  o_dbg_state
);
  enc_state_t       state;
  logic             valid_q;
  logic             last_q;
  logic [31:0]      instr_q;
  logic [31:0]      lo_word_q;
  logic [CNT_W-1:0] count_q;

  logic             two_word;
  logic [31:0]      word0;
  logic [31:0]      word1;
  logic             accept;
  logic             xfer;

  imm_classify u_classify (
    .value    (bus.i_data_value),
    .rt       (bus.i_data_rt),
    .two_word (two_word),
    .word0    (word0),
    .word1    (word1)
  );

  assign accept = bus.i_valid && (state == IDLE);
  assign xfer   = valid_q && bus.i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      instr_q   <= 32'd0;
      lo_word_q <= 32'd0;
      count_q   <= '0;
    end else begin
      if (xfer && (count_q != '1)) begin
        count_q <= count_q + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (accept) begin
            instr_q   <= word0;
            last_q    <= !two_word;
            lo_word_q <= word1;
            valid_q   <= 1'b1;
            state     <= two_word ? EMIT_HI : EMIT_ONE;
          end
        end
        EMIT_HI: begin
          // Second word follows directly so a ready sink sees no bubble.
          if (bus.i_ready) begin
            instr_q <= lo_word_q;
            last_q  <= 1'b1;
            state   <= EMIT_LO;
          end
        end
        EMIT_ONE, EMIT_LO: begin
          if (bus.i_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_ready      = (state == IDLE);
  assign bus.o_valid      = valid_q;
  assign bus.o_data_instr = instr_q;
  assign bus.o_data_last  = last_q;
  assign bus.o_data_count = count_q;
  assign o_dbg_state      = state;
endmodule

// File: tb/tb_imm_encoder.sv
// Directed plus randomized bench for imm_encoder against a value-range model
// of the shortest load sequence.
module tb_imm_encoder;
  import imm_pkg::*;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic i_clk = 1'b0;
  logic i_rst;
  enc_state_t dbg_state;

  always #5 i_clk = ~i_clk;

  imm_encoder_if #(.CNT_W(CNT_W)) bus ();

  imm_encoder #(.CNT_W(CNT_W)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int model_count = 0;
  logic [32:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: choose the encoding from the numeric range of the constant.
  function automatic void model_push(input logic [31:0] value, input logic [4:0] rt);
    int signed sv;
    logic [15:0] lo;
    logic [15:0] hi;
    sv = $signed(value);
    lo = value[15:0];
    hi = value[31:16];
    if (rt == 5'd0)
      exp_q.push_back({1'b1, 32'h0});
    else if (sv >= -32768 && sv <= 32767)
      exp_q.push_back({1'b1, 6'b001000, 5'd0, rt, lo});
    else if (value <= 32'h0000_FFFF)
      exp_q.push_back({1'b1, 6'b001101, 5'd0, rt, lo});
    else if ((value % 65536) == 0)
      exp_q.push_back({1'b1, 6'b001111, 5'd0, rt, hi});
    else begin
      exp_q.push_back({1'b0, 6'b001111, 5'd0, rt, hi});
      exp_q.push_back({1'b1, 6'b001101, rt, rt, lo});
    end
  endfunction

  task automatic reset_dut();
    i_rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_data_value = 32'd0;
    bus.i_data_rt = 5'd0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    exp_q.delete();
    model_count = 0;
  endtask

  // Presents one request and returns #1 after the accepting edge (cycle N+1).
  task automatic send(input logic [31:0] value, input logic [4:0] rt);
    int n;
    n = 0;
    model_push(value, rt);
    bus.i_data_value = value;
    bus.i_data_rt = rt;
    bus.i_valid = 1'b1;
    while (!bus.o_ready && n < 50) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (n >= 50) check("accept_timeout", 64'(n), 64'd0);
    @(posedge i_clk); #1;
    bus.i_valid = 1'b0;
    bus.i_data_value = $urandom;
    bus.i_data_rt = 5'($urandom_range(0, 31));
  endtask

  task automatic drain(input string tag, input bit rand_ready);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      bus.i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      check({tag, "_valid"}, 64'(bus.o_valid), 64'd1);
      check({tag, "_word"}, 64'({bus.o_data_last, bus.o_data_instr}), 64'(exp_q[0]));
      if (bus.i_ready) begin
        void'(exp_q.pop_front());
        if (model_count < CNT_MAX) model_count++;
      end
      @(posedge i_clk); #1;
      n++;
    end
    bus.i_ready = 1'b0;
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_idle_valid"}, 64'(bus.o_valid), 64'd0);
    check({tag, "_idle_ready"}, 64'(bus.o_ready), 64'd1);
    check({tag, "_count"}, 64'(bus.o_data_count), 64'(model_count));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [4:0]  rt;
    logic [31:0] held;

    // Reset state
    reset_dut();
    check("rst_valid", 64'(bus.o_valid), 64'd0);
    check("rst_instr", 64'(bus.o_data_instr), 64'd0);
    check("rst_last", 64'(bus.o_data_last), 64'd0);
    check("rst_count", 64'(bus.o_data_count), 64'd0);
    check("rst_ready", 64'(bus.o_ready), 64'd1);

    // Single-word encodings
    send(32'hFFFF_8000, 5'd5);
    check("addi_literal", 64'(bus.o_data_instr), 64'h2005_8000);
    drain("addi", 1'b0);
    check("addi_count1", 64'(bus.o_data_count), 64'd1);
    send(32'h0000_ABCD, 5'd9);
    check("ori_literal", 64'(bus.o_data_instr), 64'h3409_ABCD);
    drain("ori", 1'b0);
    send(32'h1234_0000, 5'd3);
    check("lui_literal", 64'(bus.o_data_instr), 64'h3C03_1234);
    drain("lui", 1'b0);

    // Two-word timing with ready held high; count restarts from reset
    reset_dut();
    send(32'h1234_ABCD, 5'd8);
    check("pair_first", 64'({bus.o_data_last, bus.o_data_instr}), 64'({1'b0, 32'h3C08_1234}));
    drain("pair", 1'b0);
    check("pair_count2", 64'(bus.o_data_count), 64'd2);

    // Backpressure on the first word, then reset while in EMIT_LO
    bus.i_ready = 1'b0;
    send(32'h1234_ABCD, 5'd8);
    held = bus.o_data_instr;
    check("stall_first", 64'(held), 64'h3C08_1234);
    bus.i_valid = 1'b1;
    bus.i_data_value = 32'h0000_0001;
    bus.i_data_rt = 5'd1;
    for (int i = 0; i < 4; i++) begin
      @(posedge i_clk); #1;
      check("stall_hold", 64'({bus.o_valid, bus.o_data_last, bus.o_data_instr}),
            64'({2'b10, 32'h3C08_1234}));
      check("stall_busy", 64'(bus.o_ready), 64'd0);
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge i_clk); #1;
    bus.i_ready = 1'b0;
    check("stall_second", 64'({bus.o_data_last, bus.o_data_instr}), 64'({1'b1, 32'h3508_ABCD}));
    check("stall_state", 64'(dbg_state), 64'(EMIT_LO));
    check("stall_count", 64'(bus.o_data_count), 64'd3);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    exp_q.delete();
    model_count = 0;
    check("midrst_valid", 64'(bus.o_valid), 64'd0);
    check("midrst_count", 64'(bus.o_data_count), 64'd0);
    check("midrst_ready", 64'(bus.o_ready), 64'd1);

    // rt=0 always yields a NOP
    send(32'hDEAD_BEEF, 5'd0);
    check("nop_literal", 64'({bus.o_data_last, bus.o_data_instr}), 64'({1'b1, 32'h0}));
    drain("nop", 1'b0);

    // Randomized requests across every encoding class, random backpressure
    for (int i = 0; i < 24; i++) begin
      rt = 5'($urandom_range(1, 31));
      case ($urandom_range(0, 4))
        0: begin v[15:0] = 16'($urandom); v[31:16] = {16{v[15]}}; end
        1: v = {16'h0, 1'b1, 15'($urandom)};
        2: v = {16'($urandom), 16'h0};
        3: v = $urandom;
        default: begin v = $urandom; rt = 5'd0; end
      endcase
      send(v, rt);
      drain("rand", 1'b1);
    end

    // Counter saturation
    reset_dut();
    bus.i_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      send(32'($urandom_range(0, 32767)), 5'($urandom_range(1, 31)));
      drain("sat_fill", 1'b0);
    end
    check("sat_full", 64'(bus.o_data_count), 64'hF);
    send(32'h0000_0042, 5'd4);
    drain("sat_extra", 1'b0);
    check("sat_hold", 64'(bus.o_data_count), 64'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
